// File: rtl/ysyx_24100012_mem_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction,
// round-robin grant on contention, registered request payload, routed response.
module ysyx_24100012_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,

  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [MASK_WIDTH-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic                  stray_resp
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } state_e;

  typedef enum logic {
    OwnIfu,
    OwnLsu
  } owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic                  stray_q, stray_d;

  logic                  grant_ifu;
  logic                  grant_lsu;

  // Grant is only offered in IDLE; on contention the side not served last wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == StIdle) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (last_grant_q == OwnIfu) begin
          grant_lsu = 1'b1;
        end else begin
          grant_ifu = 1'b1;
        end
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    stray_d      = stray_q;

    unique case (state_q)
      StIdle: begin
        if (grant_lsu) begin
          state_d      = StReq;
          owner_d      = OwnLsu;
          last_grant_d = OwnLsu;
          wen_d        = lsu_wen;
          addr_d       = lsu_addr;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
        end else if (grant_ifu) begin
          state_d      = StReq;
          owner_d      = OwnIfu;
          last_grant_d = OwnIfu;
          wen_d        = 1'b0;
          addr_d       = ifu_addr;
          wdata_d      = '0;
          wmask_d      = '0;
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (mem_resp_valid) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A response outside RESP belongs to no transaction; flag it, never forward it.
    if (mem_resp_valid && (state_q != StResp)) begin
      stray_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnIfu;
      last_grant_q <= OwnIfu;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      stray_q      <= stray_d;
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;

  assign mem_req_valid  = (state_q == StReq);
  assign mem_wen        = wen_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;

  assign ifu_resp_valid = (state_q == StResp) && mem_resp_valid && (owner_q == OwnIfu);
  assign lsu_resp_valid = (state_q == StResp) && mem_resp_valid && (owner_q == OwnLsu);
  assign ifu_rdata      = mem_rdata;
  assign lsu_rdata      = mem_rdata;

  assign stray_resp     = stray_q;

endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Directed self-checking bench for ysyx_24100012_mem_arbiter; the bench plays
// both requesters and the memory, with hand-computed expectations.
module tb_ysyx_24100012_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        stray_resp;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ysyx_24100012_mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_wen        (lsu_wen),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .stray_resp     (stray_resp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
    bit          exp_lsu;
    int          ni;
    int          nl;

    rst            = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    lsu_req_valid  = 1'b0;
    lsu_wen        = 1'b0;
    lsu_addr       = '0;
    lsu_wdata      = '0;
    lsu_wmask      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    // Reset values
    repeat (2) tick();
    settle();
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_wen_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
    check("rst_stray", 64'(stray_resp), 64'd0);
    check("rst_resp_valid", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    rst = 1'b1;
    tick();

    // Single IFU read, memory ready at once, response one cycle later
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    settle();
    check("a_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'b10);
    check("a_mreq_idle", 64'(mem_req_valid), 64'd0);
    tick();
    ifu_req_valid = 1'b0;
    ifu_addr      = '0;
    mem_req_ready = 1'b1;
    settle();
    check("a_mreq", 64'(mem_req_valid), 64'd1);
    check("a_addr", 64'(mem_addr), 64'h8000_0004);
    check("a_wen_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
    check("a_ready_in_req", 64'(ifu_req_ready), 64'd0);
    check("a_no_early_resp", 64'(ifu_resp_valid), 64'd0);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0010_0073;
    settle();
    check("a_ifu_resp", 64'(ifu_resp_valid), 64'd1);
    check("a_ifu_rdata", 64'(ifu_rdata), 64'h0010_0073);
    check("a_lsu_resp", 64'(lsu_resp_valid), 64'd0);
    check("a_mreq_resp", 64'(mem_req_valid), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("a_resp_pulse", 64'(ifu_resp_valid), 64'd0);
    check("a_stray", 64'(stray_resp), 64'd0);

    // Contention, 4 transactions each: expected order L, I, L, I, ...
    ni            = 0;
    nl            = 0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h8000_1000;
    for (int k = 0; k < 8; k++) begin
      exp_lsu  = (k % 2 == 0);
      exp_addr = exp_lsu ? 32'h8000_1000 + 32'(4 * nl) : 32'h8000_0000 + 32'(4 * ni);
      settle();
      check("c_grant", 64'({ifu_req_ready, lsu_req_ready}), exp_lsu ? 64'b01 : 64'b10);
      tick();
      if (exp_lsu) begin
        nl++;
        lsu_addr = 32'h8000_1000 + 32'(4 * nl);
        if (nl == 4) lsu_req_valid = 1'b0;
      end else begin
        ni++;
        ifu_addr = 32'h8000_0000 + 32'(4 * ni);
        if (ni == 4) ifu_req_valid = 1'b0;
      end
      mem_req_ready = 1'b1;
      settle();
      check("c_addr", 64'(mem_addr), 64'(exp_addr));
      check("c_wen", 64'(mem_wen), 64'd0);
      tick();
      exp_rd         = ~exp_addr;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = exp_rd;
      settle();
      check("c_resp", 64'({ifu_resp_valid, lsu_resp_valid}), exp_lsu ? 64'b01 : 64'b10);
      check("c_rdata", exp_lsu ? 64'(lsu_rdata) : 64'(ifu_rdata), 64'(exp_rd));
      tick();
      mem_resp_valid = 1'b0;
    end

    // LSU store with memory back-pressure for 3 cycles
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b1;
    lsu_addr      = 32'h8000_0100;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'b0011;
    settle();
    check("s_ready", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_valid = 1'b0;
    lsu_wen       = 1'b0;
    lsu_addr      = '0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      settle();
      check("s_mreq", 64'(mem_req_valid), 64'd1);
      check("s_addr", 64'(mem_addr), 64'h8000_0100);
      check("s_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      check("s_wen_wmask", 64'({mem_wen, mem_wmask}), 64'b10011);
      tick();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0;
    settle();
    check("s_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'b01);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("s_resp_pulse", 64'(lsu_resp_valid), 64'd0);
    check("s_stray", 64'(stray_resp), 64'd0);

    // Response while IDLE is dropped and latched as stray
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_AAAA;
    settle();
    check("x_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("x_stray_set", 64'(stray_resp), 64'd1);
    repeat (3) tick();
    settle();
    check("x_stray_hold", 64'(stray_resp), 64'd1);

    // LSU load with 5-cycle response delay while IFU waits
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_0200;
    settle();
    check("d_lsu_ready", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0300;
    mem_req_ready = 1'b1;
    settle();
    check("d_ifu_ready_req", 64'(ifu_req_ready), 64'd0);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("d_ifu_ready_wait", 64'(ifu_req_ready), 64'd0);
      check("d_no_resp_wait", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    settle();
    check("d_lsu_resp", 64'(lsu_resp_valid), 64'd1);
    check("d_lsu_rdata", 64'(lsu_rdata), 64'h1234_5678);
    check("d_ifu_ready_resp", 64'(ifu_req_ready), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("d_ifu_accept", 64'(ifu_req_ready), 64'd1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    check("d_ifu_addr", 64'(mem_addr), 64'h8000_0300);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0005;
    settle();
    check("d_ifu_resp", 64'(ifu_resp_valid), 64'd1);
    tick();
    mem_resp_valid = 1'b0;

    // Reset asserted mid-REQ with memory stalled
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0400;
    tick();
    ifu_req_valid = 1'b0;
    settle();
    check("r_mreq_before", 64'(mem_req_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("r_mreq_abort", 64'(mem_req_valid), 64'd0);
    check("r_stray_clear", 64'(stray_resp), 64'd0);
    check("r_addr_clear", 64'(mem_addr), 64'd0);
    tick();
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    settle();
    check("r_idle_ready", 64'(ifu_req_ready), 64'd1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    check("r_addr", 64'(mem_addr), 64'h8000_0000);
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hABCD_0001;
    settle();
    check("r_ifu_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'b10);
    check("r_ifu_rdata", 64'(ifu_rdata), 64'hABCD_0001);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("r_stray_still_clear", 64'(stray_resp), 64'd0);

    // Reset in RESP, then the late response lands in IDLE as stray
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0008;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst           = 1'b0;
    tick();
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    settle();
    check("r_late_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("r_late_stray", 64'(stray_resp), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
